// File: rtl/gpu_reg_pkg.sv
// Shared encodings for the register-port initiator: command opcodes and FSM states.
package gpu_reg_pkg;

    localparam int OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        OP_READ  = 2'd0,
        OP_WRITE = 2'd1,
        OP_POLL  = 2'd2,
        OP_RSVD  = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_RESP
    } state_e;

endpackage

// File: rtl/gpu_reg_initiator.sv
// Command-driven master for a one-cycle-latency register port (READ / WRITE / POLL).
// POLL is built only when GPU_REG_INITIATOR_POLL_EN is defined; otherwise op 2 is rejected.
module gpu_reg_initiator
    import gpu_reg_pkg::*;
#(
    parameter  int BYTES_PER_REG = 4,
    parameter  int REG_COUNT     = 32,
    parameter  int POLL_MAX      = 1024,
    localparam int W             = 8 * BYTES_PER_REG,
    localparam int A             = $clog2(REG_COUNT * BYTES_PER_REG)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     cmd_valid_i,
    output logic                     cmd_ready_o,
    input  logic [1:0]               cmd_op_i,
    input  logic [A-1:0]             cmd_addr_i,
    input  logic [W-1:0]             cmd_data_i,
    input  logic [BYTES_PER_REG-1:0] cmd_be_i,
    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic [W-1:0]             rsp_data_o,
    output logic                     rsp_err_o,
    output logic                     reg_en_o,
    output logic [A-1:0]             reg_addr_o,
    output logic [BYTES_PER_REG-1:0] reg_we_o,
    output logic [W-1:0]             reg_din_o,
    input  logic [W-1:0]             reg_dout_i
);

    localparam logic [A-1:0] ALIGN_MASK = A'(BYTES_PER_REG - 1);

    state_e         state_q, state_d;
    op_e            cmd_op;
    logic           accept, misaligned, op_ok;
    logic [A-1:0]   addr_q;
    logic           rsp_load, rsp_err_d;
    logic [W-1:0]   rsp_data_d;
    logic           poll_retry, poll_fail;

    // Ready is gated by reset so every output reads 0 while rst_i is high.
    assign cmd_ready_o = (state_q == ST_IDLE) && !rst_i;
    assign accept      = cmd_valid_i && cmd_ready_o;
    assign cmd_op      = op_e'(cmd_op_i);
    assign misaligned  = |(cmd_addr_i & ALIGN_MASK);

`ifdef GPU_REG_INITIATOR_POLL_EN
    localparam int            CW         = $clog2(POLL_MAX + 1);
    localparam logic [CW-1:0] POLL_LIMIT = CW'(POLL_MAX);

    op_e                      op_q;
    logic [W-1:0]             data_q;
    logic [BYTES_PER_REG-1:0] be_q;
    logic [CW-1:0]            poll_cnt_q;
    logic [W-1:0]             byte_mask;
    logic                     poll_match, is_poll;

    assign op_ok = (cmd_op != OP_RSVD);

    always_comb begin
        byte_mask = '0;
        for (int b = 0; b < BYTES_PER_REG; b++)
            byte_mask[b*8 +: 8] = {8{be_q[b]}};
    end

    // An all-zero mask compares nothing, so the first read always matches.
    assign poll_match = (((reg_dout_i ^ data_q) & byte_mask) == '0);
    assign is_poll    = (op_q == OP_POLL);
    assign poll_fail  = is_poll && !poll_match;
    assign poll_retry = poll_fail && (poll_cnt_q < POLL_LIMIT);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            op_q       <= OP_READ;
            data_q     <= '0;
            be_q       <= '0;
            poll_cnt_q <= '0;
        end else if (accept) begin
            op_q       <= cmd_op;
            data_q     <= cmd_data_i;
            be_q       <= cmd_be_i;
            poll_cnt_q <= '0;
        end else if (state_q == ST_RD_REQ && poll_cnt_q != POLL_LIMIT) begin
            poll_cnt_q <= poll_cnt_q + CW'(1);
        end
    end
`else
    assign op_ok      = (cmd_op == OP_READ) || (cmd_op == OP_WRITE);
    assign poll_fail  = 1'b0;
    assign poll_retry = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)       state_q <= ST_IDLE;
        else             state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        rsp_load   = 1'b0;
        rsp_data_d = '0;
        rsp_err_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (misaligned || !op_ok) begin
                        state_d   = ST_RESP;
                        rsp_load  = 1'b1;
                        rsp_err_d = 1'b1;
                    end else if (cmd_op == OP_WRITE) begin
                        state_d = ST_WR;
                    end else begin
                        state_d = ST_RD_REQ;
                    end
                end
            end
            ST_WR: begin
                state_d  = ST_RESP;
                rsp_load = 1'b1;
            end
            ST_RD_REQ:  state_d = ST_RD_WAIT;
            ST_RD_WAIT: begin
                if (poll_retry) begin
                    state_d = ST_RD_REQ;
                end else begin
                    state_d    = ST_RESP;
                    rsp_load   = 1'b1;
                    rsp_data_d = reg_dout_i;
                    rsp_err_d  = poll_fail;
                end
            end
            ST_RESP: begin
                if (rsp_valid_o && rsp_ready_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)       addr_q <= '0;
        else if (accept) addr_q <= cmd_addr_i;
    end

    // Port outputs are registered from the next state so they line up with WR / RD_REQ.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            reg_en_o   <= 1'b0;
            reg_addr_o <= '0;
            reg_we_o   <= '0;
            reg_din_o  <= '0;
        end else begin
            reg_en_o   <= (state_d == ST_WR) || (state_d == ST_RD_REQ);
            reg_we_o   <= (state_d == ST_WR) ? cmd_be_i   : '0;
            reg_din_o  <= (state_d == ST_WR) ? cmd_data_i : '0;
            if ((state_d == ST_WR) || (state_d == ST_RD_REQ))
                reg_addr_o <= (state_q == ST_IDLE) ? cmd_addr_i : addr_q;
            else
                reg_addr_o <= '0;
        end
    end

    // Response payload is captured on entry to RESP; valid follows one cycle later
    // and drops on the handshake edge, so IDLE never overlaps a completing response.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rsp_valid_o <= 1'b0;
            rsp_data_o  <= '0;
            rsp_err_o   <= 1'b0;
        end else begin
            rsp_valid_o <= (state_q == ST_RESP) && !(rsp_valid_o && rsp_ready_i);
            if (rsp_load) begin
                rsp_data_o <= rsp_data_d;
                rsp_err_o  <= rsp_err_d;
            end
        end
    end

endmodule
